instruction_fetch: RTL and testbench

Fetch front end that drives the byte address of the instruction memory and captures the 32-bit little-endian word it returns. It owns the program counter, buffers fetched words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. Branch redirects flush the buffer and restart fetch at a new PC. It sits between the instruction memory (purely combinational read) and the decode stage.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_fifo.sv | 89 ++++++++
 rtl/instruction_fetch.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Bytes per instruction word; the PC advances by this much per fetch
  localparam int INST_BYTES = 4;

  // One buffered fetch: the address it came from and the word returned
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of fetched words. A flush discards all entries at once.
// DEPTH must be a power of two so that the pointers wrap naturally.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            wr_en_s;
  logic            rd_en_s;

  // Qualify push/pop; a flush overrides both
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (flush) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = push;
      rd_en_s = pop && (count_r != {CW{1'b0}});
    end
  end

  // Storage array write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10: begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
          count_r  <= count_r + CW'(1);
        end
        2'b01: begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
          count_r  <= count_r - CW'(1);
        end
        2'b11: begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {CW{1'b0}});
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, drives the instruction memory
// address, buffers returned words with their PCs and presents them to
// decode over valid/ready. Redirects flush the buffer and reload the PC.
// Optional build macro IFETCH_PERF_COUNTERS_EN adds the fetch and stall
// counters; without it both counter ports read as zero.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  output logic [63:0] adr,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  state_t       state_r;
  state_t       state_nxt_s;
  logic [63:0]  pc_r;
  logic [63:0]  redirect_tgt_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t head_s;
  fetch_entry_t wentry_s;
  fetch_entry_t hold_r;

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wentry_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Word-aligned redirect target; the two low address bits are discarded
  assign redirect_tgt_s = redirect_pc & ~64'h3;

  // Push/pop arbitration: redirect wins, push may reuse a slot freed by pop
  always_comb begin
    pop_s    = 1'b0;
    push_s   = 1'b0;
    wentry_s = '{pc: pc_r, instr: Instruction};
    if (redirect_valid) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      pop_s = !empty_s && inst_ready;
      if ((state_r == RUN) && !halt && (!full_s || pop_s)) begin
        push_s = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // Sequencer next state; redirects never change state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED: begin
        if (!halt) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Program counter: redirect load, advance on push, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_tgt_s;
    end else if (push_s) begin
      pc_r <= pc_r + 64'(INST_BYTES);
    end else begin
      pc_r <= pc_r;
    end
  end

  // Remember the last presented head so outputs hold while the buffer is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= '0;
    end else if (!empty_s) begin
      hold_r <= head_s;
    end else begin
      hold_r <= hold_r;
    end
  end

  assign adr        = pc_r;
  assign inst_valid = !empty_s;
  assign inst_out   = empty_s ? hold_r.instr : head_s.instr;
  assign inst_pc    = empty_s ? hold_r.pc    : head_s.pc;

`ifdef IFETCH_PERF_COUNTERS_EN
  logic        stall_s;
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;

  // A stall is a RUN cycle where the buffer is full and nothing leaves it
  assign stall_s = (state_r == RUN) && full_s && !pop_s;

  // Performance counters, free-running and wrapping, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_r <= 32'h0;
      stall_count_r <= 32'h0;
    end else begin
      fetch_count_r <= push_s  ? fetch_count_r + 32'd1 : fetch_count_r;
      stall_count_r <= stall_s ? stall_count_r + 32'd1 : stall_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch;

  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC2  = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef IFETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst_n, start, halt, redir, ready;
  logic [63:0] rpc;
  logic [63:0] adr, inst_pc, adr2, inst_pc2;
  logic [31:0] instr, inst_out, fcnt, scnt, instr2, inst_out2, fcnt2, scnt2;
  logic        inst_valid, inst_valid2;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] memword(input logic [63:0] a);
    logic [7:0] i;
    i = a[7:0];
    return {mem[i + 8'd3], mem[i + 8'd2], mem[i + 8'd1], mem[i]};
  endfunction

  assign instr  = memword(adr);
  assign instr2 = memword(adr2);

  instruction_fetch #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .adr(adr),
    .Instruction(instr), .redirect_valid(redir), .redirect_pc(rpc),
    .inst_valid(inst_valid), .inst_ready(ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .fetch_count(fcnt), .stall_count(scnt));

  instruction_fetch #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(1'b0), .adr(adr2),
    .Instruction(instr2), .redirect_valid(1'b0), .redirect_pc(64'h0),
    .inst_valid(inst_valid2), .inst_ready(1'b1), .inst_out(inst_out2),
    .inst_pc(inst_pc2), .fetch_count(fcnt2), .stall_count(scnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [63:0] mpc;
  int          mst;          // 0 idle, 1 running, 2 halted
  logic [31:0] mfc, msc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mpc = 64'h0;
      mst = 0;
      mfc = 32'h0;
      msc = 32'h0;
    end else begin
      bit pop, push, stall;
      pop   = (q.size() > 0) && ready && !redir;
      push  = (mst == 1) && !halt && !redir && ((q.size() < DEPTH) || pop);
      stall = (mst == 1) && (q.size() == DEPTH) && !pop;
      if (redir) begin
        q.delete();
        mpc = {redirect_pc_hi(rpc), 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back('{pc: mpc, ins: memword(mpc)});
          mpc = mpc + 64'd4;
          mfc = mfc + 32'd1;
        end
      end
      if (stall) msc = msc + 32'd1;
      case (mst)
        0: if (start) mst = 1;
        1: if (halt) mst = 2;
        2: if (!halt) mst = 1;
        default: mst = 0;
      endcase
    end
  end

  function automatic logic [61:0] redirect_pc_hi(input logic [63:0] p);
    return p[63:2];
  endfunction

  // Compare DUT against model every cycle, away from the rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("adr", adr, mpc);
      chk("inst_valid", {63'h0, inst_valid}, {63'h0, q.size() > 0});
      if (q.size() > 0) begin
        chk("inst_out", {32'h0, inst_out}, {32'h0, q[0].ins});
        chk("inst_pc", inst_pc, q[0].pc);
      end
      chk("fetch_count", {32'h0, fcnt}, PERF ? {32'h0, mfc} : 64'h0);
      chk("stall_count", {32'h0, scnt}, PERF ? {32'h0, msc} : 64'h0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; halt = 1'b0; redir = 1'b0; ready = 1'b0; rpc = 64'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[0]  = 8'he5; mem[1]  = 8'h03; mem[2]  = 8'h1f; mem[3]  = 8'h8b;
    mem[4]  = 8'ha4; mem[5]  = 8'h00; mem[6]  = 8'h40; mem[7]  = 8'hf8;
    mem[8]  = 8'h86; mem[9]  = 8'h00; mem[10] = 8'h04; mem[11] = 8'h8b;
    mem[12] = 8'ha6; mem[13] = 8'h10; mem[14] = 8'h00; mem[15] = 8'hf8;
    rst_n = 1'b1; start = 1'b0; halt = 1'b0; redir = 1'b0; ready = 1'b0;
    rpc = 64'h0;
    #3 rst_n = 1'b0;

    // Scenario 1: straight-line fetch, wrap on the second DUT, async reset
    do_reset();
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_adr", adr, 64'h0);
    chk("rst_out", {32'h0, inst_out}, 64'h0);
    chk("rst_pc", inst_pc, 64'h0);
    chk("rst_fc", {32'h0, fcnt}, 64'h0);
    chk("rst_sc", {32'h0, scnt}, 64'h0);
    chk("rst_adr2", adr2, RPC2);
    ready = 1'b1; start = 1'b1;
    cyc(1); start = 1'b0;                                   // cycle 1
    chk("c1_valid", {63'h0, inst_valid}, 64'h0);
    chk("c1_adr2", adr2, RPC2);
    cyc(1);                                                 // cycle 2
    chk("s1_out0", {32'h0, inst_out}, 64'h8b1f03e5);
    chk("s1_pc0", inst_pc, 64'h0);
    chk("wrap_adr2", adr2, 64'h0);
    chk("wrap_pc2a", inst_pc2, RPC2);
    cyc(1);                                                 // cycle 3
    chk("s1_out1", {32'h0, inst_out}, 64'hf84000a4);
    chk("s1_pc1", inst_pc, 64'h4);
    chk("wrap_pc2b", inst_pc2, 64'h0);
    cyc(1);
    chk("s1_out2", {32'h0, inst_out}, 64'h8b040086);
    chk("s1_pc2", inst_pc, 64'h8);
    cyc(1);
    chk("s1_out3", {32'h0, inst_out}, 64'hf80010a6);
    chk("s1_pc3", inst_pc, 64'hc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'h0, inst_valid}, 64'h0);
    chk("arst_adr", adr, 64'h0);
    chk("arst_adr2", adr2, RPC2);
    @(negedge clk); rst_n = 1'b1;
    cyc(3);
    chk("idle_valid", {63'h0, inst_valid}, 64'h0);
    chk("idle_adr", adr, 64'h0);

    // Scenario 2: back-pressure fills the buffer, then drains in order
    do_reset();
    ready = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(4);                                                 // cycle 5
    chk("bp_adr", adr, 64'h8);
    chk("bp_fc", {32'h0, fcnt}, PERF ? 64'd2 : 64'd0);
    chk("bp_sc", {32'h0, scnt}, PERF ? 64'd2 : 64'd0);
    chk("bp_pc0", inst_pc, 64'h0);
    ready = 1'b1;
    cyc(1);
    chk("bp_pc1", inst_pc, 64'h4);
    chk("bp_out1", {32'h0, inst_out}, 64'hf84000a4);
    cyc(1);
    chk("bp_pc2", inst_pc, 64'h8);
    cyc(4);

    // Scenario 3: misaligned redirect while the buffer holds two entries
    do_reset();
    ready = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(3);                                                 // cycle 4
    redir = 1'b1; rpc = 64'h6;
    cyc(1); redir = 1'b0; ready = 1'b1;
    chk("rd_valid", {63'h0, inst_valid}, 64'h0);
    chk("rd_adr", adr, 64'h4);
    cyc(1);
    chk("rd_out", {32'h0, inst_out}, 64'hf84000a4);
    chk("rd_pc", inst_pc, 64'h4);
    cyc(3);

    // Scenario 4: halt for three cycles, buffer drains, resume at held PC
    do_reset();
    ready = 1'b1; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(2); halt = 1'b1;                                    // cycle 3
    cyc(2);                                                 // cycle 5
    chk("h_adr", adr, 64'h8);
    chk("h_valid", {63'h0, inst_valid}, 64'h0);
    cyc(1); halt = 1'b0;
    chk("h_adr2", adr, 64'h8);
    cyc(2);                                                 // cycle 8
    chk("h_valid2", {63'h0, inst_valid}, 64'h1);
    chk("h_pc", inst_pc, 64'h8);
    chk("h_out", {32'h0, inst_out}, 64'h8b040086);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
